// File: rtl/fifo_rd_stream.sv
// Read-side drain stage of the async FIFO: pops against fifo_empty, lands the registered
// read data in a small prefetch ring and replays it as a valid/ready stream.
module fifo_rd_stream #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 16
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_r_en,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W:0]   OCC_CAP  = (OCC_W + 1)'(DEPTH);

    logic [DATA_W-1:0] buffer [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  occ_next;
    logic              inflight_q;
    logic [OCC_W:0]    pending;
    logic              arrive;
    logic              xfer;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Words already buffered plus the one in flight reserve space, so occ can never overflow.
    assign pending   = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};
    assign fifo_r_en = rrst_n & ~flush & ~fifo_empty & (pending < OCC_CAP);

    assign m_valid = (occ != '0) & ~flush;
    assign m_data  = buffer[rd_ptr];
    assign xfer    = m_valid & m_ready;
    assign arrive  = inflight_q & ~flush;

    always_comb begin
        occ_next = occ;
        unique case ({arrive, xfer})
            2'b10:   occ_next = occ + OCC_W'(1);
            2'b01:   occ_next = occ - OCC_W'(1);
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ        <= '0;
            inflight_q <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else if (flush) begin
            occ        <= '0;
            inflight_q <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            occ        <= occ_next;
            inflight_q <= fifo_r_en;
            if (arrive) wr_ptr <= next_ptr(wr_ptr);
            if (xfer)   rd_ptr <= next_ptr(rd_ptr);
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
        end else if (arrive) begin
            buffer[wr_ptr] <= fifo_data;
        end
    end

    // Flush leaves the delivered count alone; only reset clears it.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            word_cnt <= '0;
        end else if (xfer) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

    occ_bounded: assert property (@(posedge rclk) disable iff (!rrst_n) {1'b0, occ} <= OCC_CAP)
        else $error("occupancy above DEPTH");
    no_pop_in_flush: assert property (@(posedge rclk) disable iff (!rrst_n) flush |-> !fifo_r_en)
        else $error("pop issued during flush");

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and randomized checks of fifo_rd_stream against a queue-level model of the
// prefetch buffer, the upstream FIFO and the delivered-word count.
module tb_fifo_rd_stream;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 3;
    localparam int CNT_W  = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic              rclk = 1'b0;
    logic              rrst_n;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_r_en;
    logic              flush;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  word_cnt;

    always #5 rclk = ~rclk;

    fifo_rd_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .word_cnt   (word_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W-1:0] exp_q[$];
    bit                inflight;
    logic [DATA_W-1:0] inflight_word;
    int                cnt_model;
    int                pops_seen;
    int                valid_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) src_q.push_back(DATA_W'($urandom));
    endtask

    // One clock: check outputs at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        bit exp_pop;
        bit exp_valid;
        fifo_empty = (src_q.size() == 0);
        @(negedge rclk);
        exp_pop   = !flush && (src_q.size() != 0) && ((exp_q.size() + int'(inflight)) < DEPTH);
        exp_valid = !flush && (exp_q.size() != 0);
        chk("fifo_r_en", 32'(fifo_r_en), 32'(exp_pop));
        chk("m_valid", 32'(m_valid), 32'(exp_valid));
        if (exp_valid) chk("m_data", 32'(m_data), 32'(exp_q[0]));
        chk("word_cnt", 32'(word_cnt), 32'(cnt_model % CNT_MOD));
        if (fifo_r_en) pops_seen++;
        if (m_valid) valid_seen++;
        @(posedge rclk);
        #1;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (exp_valid && m_ready) begin
                void'(exp_q.pop_front());
                cnt_model++;
            end
            if (inflight) exp_q.push_back(inflight_word);
        end
        inflight = exp_pop;
        if (exp_pop) begin
            inflight_word = src_q.pop_front();
            fifo_data     = inflight_word;
        end else begin
            fifo_data = DATA_W'($urandom);
        end
    endtask

    // Assert reset between clock edges and confirm the outputs clear without waiting for an edge.
    task automatic hard_reset();
        #2;
        rrst_n = 1'b0;
        #1;
        chk("rst_fifo_r_en", 32'(fifo_r_en), 32'(0));
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_m_data", 32'(m_data), 32'(0));
        chk("rst_word_cnt", 32'(word_cnt), 32'(0));
        exp_q.delete();
        src_q.delete();
        inflight  = 1'b0;
        cnt_model = 0;
        flush      = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        repeat (2) @(posedge rclk);
        #1;
        rrst_n = 1'b1;
    endtask

    initial begin
        logic [DATA_W-1:0] nxt;
        int p0;
        int v0;
        rrst_n     = 1'b1;
        flush      = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        inflight   = 1'b0;
        cnt_model  = 0;
        pops_seen  = 0;
        valid_seen = 0;
        hard_reset();

        // Idle after reset with an empty FIFO.
        for (int i = 0; i < 20; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            cycle();
        end

        // Streaming 0x01..0x0A with the consumer always ready.
        for (int i = 1; i <= 10; i++) src_q.push_back(DATA_W'(i));
        m_ready = 1'b1;
        p0 = pops_seen;
        v0 = valid_seen;
        repeat (10) cycle();
        chk("stream_pops", 32'(pops_seen - p0), 32'(10));
        repeat (4) cycle();
        chk("stream_valid_cycles", 32'(valid_seen - v0), 32'(10));
        chk("stream_word_cnt", 32'(word_cnt), 32'(10));

        // Backpressure: exactly DEPTH pops, head word held, then ordered drain.
        m_ready = 1'b0;
        push_words(6);
        p0 = pops_seen;
        repeat (6) cycle();
        chk("bp_pops", 32'(pops_seen - p0), 32'(3));
        chk("bp_m_valid", 32'(m_valid), 32'(1));
        chk("bp_m_data", 32'(m_data), 32'(exp_q[0]));
        m_ready = 1'b1;
        repeat (8) cycle();
        chk("bp_drain_cnt", 32'(word_cnt), 32'((10 + 6) % CNT_MOD));

        // Flush with two words buffered and one in flight.
        m_ready = 1'b0;
        push_words(6);
        repeat (3) cycle();
        chk("pre_flush_valid", 32'(m_valid), 32'(1));
        nxt   = src_q[0];
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        repeat (2) cycle();
        chk("post_flush_valid", 32'(m_valid), 32'(1));
        chk("post_flush_data", 32'(m_data), 32'(nxt));
        m_ready = 1'b1;
        repeat (8) cycle();

        // Multi-cycle flush in the middle of a running stream.
        push_words(5);
        repeat (3) cycle();
        flush = 1'b1;
        repeat (3) cycle();
        flush = 1'b0;
        repeat (8) cycle();

        // Randomized traffic, backpressure and occasional flushes.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) push_words($urandom_range(1, 3));
            m_ready = 1'($urandom_range(0, 1));
            flush   = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush   = 1'b0;
        m_ready = 1'b1;
        repeat (12) cycle();

        // Counter and pointer wrap: 20 transfers on a 4-bit counter.
        hard_reset();
        for (int i = 0; i < 20; i++) src_q.push_back(DATA_W'(8'h40 + i));
        m_ready = 1'b1;
        repeat (24) cycle();
        chk("wrap_word_cnt", 32'(word_cnt), 32'(4));

        // Asynchronous reset with the buffer full, then resume.
        m_ready = 1'b0;
        push_words(6);
        repeat (4) cycle();
        chk("pre_rst_valid", 32'(m_valid), 32'(1));
        hard_reset();
        push_words(8);
        m_ready = 1'b1;
        repeat (12) cycle();
        chk("resume_word_cnt", 32'(word_cnt), 32'(8));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
